riscv32_mem_arbiter: RTL and testbench

RISCV32_MEM_ARBITER -- requirements
Module: riscv32_mem_arbiter

---
 rtl/riscv32_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_riscv32_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv32_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single memory port.
// One transaction in flight; data wins unless fetch has been starved STARVE_MAX times.
module riscv32_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, LOCK, WAIT} state_e;

  state_e              state_q;
  logic                own_d_q;   // 1: data port owns the current transaction
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                lk_we_q;
  logic [BE_W-1:0]     lk_be_q;
  logic [ADDR_W-1:0]   lk_addr_q;
  logic [DATA_W-1:0]   lk_wdata_q;

  logic                any_req, win_d, sel_d, gnt_ev, rsp_ev;
  logic                win_we;
  logic [BE_W-1:0]     win_be;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  assign any_req = if_req | d_req;
  assign win_d   = d_req & ~(if_req & (starve_q == STARVE_LIM));

  // Fetch is always a full-word read
  always_comb begin
    win_we    = 1'b0;
    win_be    = '1;
    win_addr  = if_addr;
    win_wdata = '0;
    if (win_d) begin
      win_we    = d_we;
      win_be    = d_be;
      win_addr  = d_addr;
      win_wdata = d_wdata;
    end
  end

  // In LOCK the latched copy is driven so late requester changes cannot leak out
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == IDLE && any_req) begin
        mem_req   = 1'b1;
        mem_we    = win_we;
        mem_be    = win_be;
        mem_addr  = win_addr;
        mem_wdata = win_wdata;
      end else if (state_q == LOCK) begin
        mem_req   = 1'b1;
        mem_we    = lk_we_q;
        mem_be    = lk_be_q;
        mem_addr  = lk_addr_q;
        mem_wdata = lk_wdata_q;
      end
    end
  end

  assign sel_d  = (state_q == IDLE) ? win_d : own_d_q;
  assign gnt_ev = mem_req & mem_gnt;
  assign if_gnt = gnt_ev & ~sel_d;
  assign d_gnt  = gnt_ev & sel_d;

  // Responses outside WAIT are stale or spurious and are dropped
  assign rsp_ev    = ~reset & (state_q == WAIT) & mem_rvalid;
  assign if_rvalid = rsp_ev & ~own_d_q;
  assign d_rvalid  = rsp_ev & own_d_q;
  assign if_rdata  = reset ? '0 : mem_rdata;
  assign d_rdata   = reset ? '0 : mem_rdata;
  assign busy      = ~reset & (state_q != IDLE);

  always_comb begin
    starve_d = starve_q;
    if (gnt_ev) begin
      if (!sel_d)
        starve_d = '0;
      else if (if_req && starve_q != STARVE_LIM)
        starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      own_d_q    <= 1'b0;
      starve_q   <= '0;
      lk_we_q    <= 1'b0;
      lk_be_q    <= '0;
      lk_addr_q  <= '0;
      lk_wdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        IDLE: if (any_req) begin
          own_d_q    <= win_d;
          lk_we_q    <= win_we;
          lk_be_q    <= win_be;
          lk_addr_q  <= win_addr;
          lk_wdata_q <= win_wdata;
          state_q    <= mem_gnt ? WAIT : LOCK;
        end
        LOCK: if (mem_gnt) state_q <= WAIT;
        WAIT: if (mem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv32_mem_arbiter.sv
// Directed bench for riscv32_mem_arbiter: transaction-level model checked every cycle
// plus literal expectations for the key scenarios.
module tb_riscv32_mem_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, SMAX = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [BW-1:0] d_be = '0;
  logic [DW-1:0] d_wdata = '0;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;

  riscv32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one pending transaction record (requesting, then accepted), plus starvation count
  logic m_busy = 1'b0, m_acc = 1'b0, m_own_d = 1'b0, acc_now;
  logic m_we = 1'b0;
  logic [BW-1:0] m_be = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  int m_starve = 0;
  logic e_req, e_we, e_ig, e_dg, e_iv, e_dv, e_busy;
  logic [BW-1:0] e_be;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd;

  always @(negedge clk) begin
    e_req = 0; e_we = 0; e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_busy = 0;
    e_be = '0; e_addr = '0; e_wd = '0; e_rd = '0;
    if (reset) begin
      m_busy = 0; m_acc = 0; m_starve = 0;
    end else begin
      acc_now = m_acc;
      e_busy  = m_busy;
      e_rd    = mem_rdata;
      if (!m_busy && (if_req || d_req)) begin
        m_own_d = d_req && !(if_req && m_starve == SMAX);
        if (m_own_d) begin
          m_we = d_we; m_be = d_be; m_addr = d_addr; m_wd = d_wdata;
        end else begin
          m_we = 0; m_be = '1; m_addr = if_addr; m_wd = '0;
        end
        m_busy = 1;
      end
      if (m_busy && !acc_now) begin
        e_req = 1; e_we = m_we; e_be = m_be; e_addr = m_addr; e_wd = m_wd;
        if (mem_gnt) begin
          e_dg = m_own_d; e_ig = !m_own_d; m_acc = 1;
          if (!m_own_d) m_starve = 0;
          else if (if_req && m_starve < SMAX) m_starve++;
        end
      end else if (acc_now && mem_rvalid) begin
        e_iv = !m_own_d; e_dv = m_own_d;
        m_busy = 0; m_acc = 0;
      end
    end
    chk("mem_req", mem_req, e_req);
    chk("mem_we", mem_we, e_we);
    chk("mem_be", mem_be, e_be);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("if_gnt", if_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("if_rvalid", if_rvalid, e_iv);
    chk("d_rvalid", d_rvalid, e_dv);
    chk("if_rdata", if_rdata, e_rd);
    chk("d_rdata", d_rdata, e_rd);
    chk("busy", busy, e_busy);
  end

  // One cycle of stimulus; returns after the falling edge so outputs are settled
  task automatic step(input logic rst, ir, dr, mg, mv, input logic [DW-1:0] rd);
    @(posedge clk); #1;
    reset = rst; if_req = ir; d_req = dr; mem_gnt = mg; mem_rvalid = mv; mem_rdata = rd;
    @(negedge clk); #1;
  endtask

  logic [9:0] glog;
  int gcount;

  initial begin
    // Reset with activity on every input
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'h1234);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_rdata", if_rdata, 0);

    // Single fetch, immediate grant, response next cycle
    if_addr = 32'h0000_0004;
    step(0, 1, 0, 1, 0, 0);
    chk("f_if_gnt", if_gnt, 1);
    chk("f_addr", mem_addr, 32'h4);
    chk("f_be", mem_be, 4'hF);
    step(0, 0, 0, 0, 1, 32'h0050_0093);
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h0050_0093);
    chk("f_d_rvalid", d_rvalid, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("f_idle", busy, 0);

    // Simultaneous requests: data write wins, fetch follows after one idle cycle
    d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF; if_addr = 32'h8;
    step(0, 1, 1, 1, 0, 0);
    chk("c_mem_we", mem_we, 1);
    chk("c_mem_addr", mem_addr, 32'h100);
    chk("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("c_d_gnt", d_gnt, 1);
    chk("c_if_gnt", if_gnt, 0);
    step(0, 1, 0, 0, 1, 0);
    chk("c_d_rvalid", d_rvalid, 1);
    chk("c_wait_noreq", mem_req, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("c_if_gnt2", if_gnt, 1);
    chk("c_if_addr", mem_addr, 32'h8);
    step(0, 0, 0, 0, 1, 32'hCAFE_0001);
    chk("c_if_rvalid", if_rvalid, 1);

    // Both requesting continuously: fetch gets every fifth slot
    glog = '0; gcount = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 1, 1, 0, 0);
      glog = {glog[8:0], d_gnt};
      gcount += int'(d_gnt | if_gnt);
      step(0, 1, 1, 0, 1, DW'(k));
    end
    chk("order", glog, 10'b1111011110);
    chk("order_cnt", gcount, 10);

    // Fetch locked for three cycles while data request arrives; stray response in LOCK
    if_addr = 32'h40; d_addr = 32'h200; d_we = 0; d_be = 4'h3;
    step(0, 1, 0, 0, 0, 0);
    chk("l_req", mem_req, 1);
    chk("l_addr0", mem_addr, 32'h40);
    step(0, 1, 1, 0, 0, 0);
    chk("l_addr1", mem_addr, 32'h40);
    chk("l_dgnt1", d_gnt, 0);
    chk("l_busy", busy, 1);
    step(0, 1, 1, 0, 1, 32'hBAD);
    chk("l_stray_if", if_rvalid, 0);
    chk("l_stray_d", d_rvalid, 0);
    step(0, 1, 1, 1, 0, 0);
    chk("l_if_gnt", if_gnt, 1);
    chk("l_dgnt3", d_gnt, 0);
    chk("l_addr3", mem_addr, 32'h40);
    step(0, 0, 1, 0, 1, 32'h11);
    chk("l_if_rvalid", if_rvalid, 1);
    step(0, 0, 1, 1, 0, 0);
    chk("l_d_gnt", d_gnt, 1);
    chk("l_d_addr", mem_addr, 32'h200);
    chk("l_d_be", mem_be, 4'h3);
    step(0, 0, 0, 0, 1, 32'h22);
    chk("l_d_rdata", d_rdata, 32'h22);

    // Reset while waiting for a response; late response must be dropped
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 32'h33);
    chk("r_busy", busy, 0);
    chk("r_d_rvalid", d_rvalid, 0);
    chk("r_mem_req", mem_req, 0);
    step(0, 0, 0, 0, 1, 32'h44);
    chk("r_late_d", d_rvalid, 0);
    chk("r_late_busy", busy, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("r_if_gnt", if_gnt, 1);
    step(0, 0, 0, 0, 1, 32'h55);
    chk("r_if_rvalid", if_rvalid, 1);

    // Spurious response in IDLE
    step(0, 0, 0, 0, 1, 32'h66);
    chk("s_if_rvalid", if_rvalid, 0);
    chk("s_d_rvalid", d_rvalid, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("s_busy", busy, 0);

    // Data grant without pending fetch leaves the starvation count alone
    glog = '0;
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 1, 0, 0); glog = {glog[8:0], d_gnt};
      step(0, 1, 1, 0, 1, 0);
    end
    step(0, 0, 1, 1, 0, 0); glog = {glog[8:0], d_gnt};
    step(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 1, 1, 0, 0); glog = {glog[8:0], d_gnt};
      step(0, 1, 1, 0, 1, 0);
    end
    chk("sat_order", glog[5:0], 6'b111110);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
